gs_ports: RTL and testbench

- NGS-side port block, directly downstream of the ZXBUS interface.
- Decodes NGS Z80 I/O cycles on ports $00-$0C.
- Gives the NGS CPU read access to the ZX command/data registers and the status bits, and holds the data byte returned to the ZX.
- Produces the single-cycle data_bit_wr/command_bit_wr strobes that the ZXBUS interface consumes. Also holds the memory page register (mpage).

---
 rtl/gs_pkg.sv | 18 +
 rtl/gs_io_strobe.sv | 49 ++++
 rtl/gs_ports.sv | 162 ++++++++++++++++
 tb/tb_gs_ports.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// gs_ports shared definitions: NGS I/O port numbers and status bit positions.
// Only the low address nibble is decoded, so port numbers are 4 bits wide.
package gs_pkg;

    localparam logic [3:0] GS_P_MPAGE = 4'h0;
    localparam logic [3:0] GS_P_CMD   = 4'h1;
    localparam logic [3:0] GS_P_DAT   = 4'h2;
    localparam logic [3:0] GS_P_WDAT  = 4'h3;
    localparam logic [3:0] GS_P_STAT  = 4'h4;
    localparam logic [3:0] GS_P_CCMD  = 4'h5;
    localparam logic [3:0] GS_P_SDAT  = 4'hA;
    localparam logic [3:0] GS_P_SCMD  = 4'hB;
    localparam logic [3:0] GS_P_INTC  = 4'hC;

    localparam int DATA_BIT = 7;
    localparam int CMD_BIT  = 0;

endpackage

// File: rtl/gs_io_strobe.sv
// Qualifies NGS Z80 I/O cycles and turns them into single-cycle
// write-start / read-end events; reads keep the port seen at read start.
module gs_io_strobe
    import gs_pkg::*;
(
    input  logic       cpu_clock,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    output logic       iord,
    output logic       wr_start,
    output logic       rd_end,
    output logic [3:0] port
);

    logic       iowr;
    logic       iord_r;
    logic       iowr_r;
    logic       armed;
    logic [3:0] port_r;

    assign iord = ~iorq_n & ~rd_n & m1_n;
    assign iowr = ~iorq_n & ~wr_n & m1_n;

    // A cycle already running when reset lifts lost its edge; wait for idle.
    always_ff @(posedge cpu_clock or posedge rst) begin
        if (rst) begin
            iord_r <= 1'b0;
            iowr_r <= 1'b0;
            armed  <= 1'b0;
            port_r <= '0;
        end else begin
            iord_r <= iord;
            iowr_r <= iowr;
            if (~iord & ~iowr)
                armed <= 1'b1;
            if (iord & ~iord_r)
                port_r <= a;
        end
    end

    assign wr_start = armed & iowr & ~iowr_r;
    assign rd_end   = armed & iord_r & ~iord;
    assign port     = wr_start ? a : port_r;

endmodule

// File: rtl/gs_ports.sv
// NGS-side port block: $00-$0C decode, handshake strobes, mpage register.
// Build option GS_CMD_INT_EN adds the command-bit interrupt on int_n.
module gs_ports
    import gs_pkg::*;
#(
    parameter int MPAGE_W = 6,
    parameter int INT_LEN = 32
) (
    input  logic               cpu_clock,
    input  logic               rst,
    input  logic [7:0]         a,
    input  logic               iorq_n,
    input  logic               rd_n,
    input  logic               wr_n,
    input  logic               m1_n,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               dout_oe,
    input  logic [7:0]         zx_command,
    input  logic [7:0]         zx_data_in,
    output logic [7:0]         zx_data_out,
    input  logic               data_bit,
    input  logic               command_bit,
    output logic               data_bit_in,
    output logic               command_bit_in,
    output logic               data_bit_wr,
    output logic               command_bit_wr,
    output logic [MPAGE_W-1:0] mpage,
    output logic               int_n
);

    logic       iord;
    logic       wr_start;
    logic       rd_end;
    logic [3:0] port;
    logic       unused_a;

    assign unused_a = ^a[7:4];

    gs_io_strobe u_strobe (
        .cpu_clock (cpu_clock),
        .rst       (rst),
        .a         (a[3:0]),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .m1_n      (m1_n),
        .iord      (iord),
        .wr_start  (wr_start),
        .rd_end    (rd_end),
        .port      (port)
    );

    always_comb begin
        dout    = '0;
        dout_oe = 1'b0;
        if (iord) begin
            case (a[3:0])
                GS_P_MPAGE: begin
                    dout[MPAGE_W-1:0] = mpage;
                    dout_oe           = 1'b1;
                end
                GS_P_CMD: begin
                    dout    = zx_command;
                    dout_oe = 1'b1;
                end
                GS_P_DAT: begin
                    dout    = zx_data_in;
                    dout_oe = 1'b1;
                end
                GS_P_STAT: begin
                    dout[DATA_BIT] = data_bit;
                    dout[CMD_BIT]  = command_bit;
                    dout_oe        = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A write start outranks a coinciding read end.
    always_ff @(posedge cpu_clock or posedge rst) begin
        if (rst) begin
            mpage          <= '0;
            zx_data_out    <= '0;
            data_bit_in    <= 1'b0;
            command_bit_in <= 1'b0;
            data_bit_wr    <= 1'b0;
            command_bit_wr <= 1'b0;
        end else begin
            data_bit_wr    <= 1'b0;
            command_bit_wr <= 1'b0;
            if (wr_start) begin
                case (port)
                    GS_P_MPAGE: mpage <= din[MPAGE_W-1:0];
                    GS_P_WDAT: begin
                        zx_data_out <= din;
                        data_bit_in <= 1'b1;
                        data_bit_wr <= 1'b1;
                    end
                    GS_P_CCMD: begin
                        command_bit_in <= 1'b0;
                        command_bit_wr <= 1'b1;
                    end
                    GS_P_SDAT: begin
                        data_bit_in <= din[0];
                        data_bit_wr <= 1'b1;
                    end
                    GS_P_SCMD: begin
                        command_bit_in <= din[0];
                        command_bit_wr <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (rd_end && port == GS_P_DAT) begin
                data_bit_in <= 1'b0;
                data_bit_wr <= 1'b1;
            end
        end
    end

`ifdef GS_CMD_INT_EN
    localparam int CW = $clog2(INT_LEN + 1);

    logic          int_ena;
    logic          cmd_bit_r;
    logic          int_n_r;
    logic [CW-1:0] int_cnt;
    logic [CW-1:0] int_cnt_nxt;

    // A fresh command_bit edge reloads the count, even mid-pulse.
    always_comb begin
        int_cnt_nxt = int_cnt;
        if (command_bit & ~cmd_bit_r & int_ena)
            int_cnt_nxt = CW'(INT_LEN);
        else if (int_cnt != '0)
            int_cnt_nxt = int_cnt - CW'(1);
    end

    always_ff @(posedge cpu_clock or posedge rst) begin
        if (rst) begin
            int_ena   <= 1'b0;
            cmd_bit_r <= 1'b0;
            int_cnt   <= '0;
            int_n_r   <= 1'b1;
        end else begin
            cmd_bit_r <= command_bit;
            int_cnt   <= int_cnt_nxt;
            int_n_r   <= (int_cnt_nxt == '0);
            if (wr_start && port == GS_P_INTC)
                int_ena <= din[0];
        end
    end

    assign int_n = int_n_r;
`else
    localparam int unused_int_len = INT_LEN;

    assign int_n = 1'b1;
`endif

endmodule

// File: tb/tb_gs_ports.sv
// Self-checking bench for gs_ports: vector table plus strobe scoreboard.
// Build with +define+GS_CMD_INT_EN to cover the interrupt option.
module tb_gs_ports;

    logic       cpu_clock = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = '0;
    logic       iorq_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       m1_n = 1'b1;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       dout_oe;
    logic [7:0] zx_command = '0;
    logic [7:0] zx_data_in = '0;
    logic [7:0] zx_data_out;
    logic       data_bit = 1'b0;
    logic       command_bit = 1'b0;
    logic       data_bit_in;
    logic       command_bit_in;
    logic       data_bit_wr;
    logic       command_bit_wr;
    logic [5:0] mpage;
    logic       int_n;

    gs_ports dut (
        .cpu_clock      (cpu_clock),
        .rst            (rst),
        .a              (a),
        .iorq_n         (iorq_n),
        .rd_n           (rd_n),
        .wr_n           (wr_n),
        .m1_n           (m1_n),
        .din            (din),
        .dout           (dout),
        .dout_oe        (dout_oe),
        .zx_command     (zx_command),
        .zx_data_in     (zx_data_in),
        .zx_data_out    (zx_data_out),
        .data_bit       (data_bit),
        .command_bit    (command_bit),
        .data_bit_in    (data_bit_in),
        .command_bit_in (command_bit_in),
        .data_bit_wr    (data_bit_wr),
        .command_bit_wr (command_bit_wr),
        .mpage          (mpage),
        .int_n          (int_n)
    );

    always #5 cpu_clock = ~cpu_clock;

    typedef struct {
        bit is_cmd;
        bit val;
    } sb_t;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        int         waits;
        logic [7:0] cmd;
        logic [7:0] dat;
        bit         db;
        bit         cb;
        logic [7:0] exp_dout;
        bit         exp_oe;
        int         strobe;
        bit         sval;
        logic [7:0] exp_zdo;
        logic [7:0] exp_mpage;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   int_low = 0;
    sb_t  sbq[$];
    logic exp_dbi = 1'b0;
    logic exp_cbi = 1'b0;
    vec_t vt[18];

    task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic expect_strobe(bit is_cmd, bit val);
        sb_t e;
        e.is_cmd = is_cmd;
        e.val    = val;
        sbq.push_back(e);
        if (is_cmd)
            exp_cbi = val;
        else
            exp_dbi = val;
    endtask

    // Every wait goes through here so strobes are scored on each cycle.
    task automatic tick();
        sb_t e;
        logic got_val;
        @(negedge cpu_clock);
        if (data_bit_wr || command_bit_wr) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: data_bit_wr=%0b command_bit_wr=%0b expected none",
                         data_bit_wr, command_bit_wr);
            end else begin
                e = sbq.pop_front();
                got_val = e.is_cmd ? command_bit_in : data_bit_in;
                if (command_bit_wr !== e.is_cmd || data_bit_wr !== !e.is_cmd || got_val !== e.val) begin
                    errors++;
                    $display("FAIL strobe: got dwr=%0b cwr=%0b val=%0b expected cmd=%0b val=%0b",
                             data_bit_wr, command_bit_wr, got_val, e.is_cmd, e.val);
                end
            end
        end
`ifdef GS_CMD_INT_EN
        if (int_n === 1'b0)
            int_low++;
`else
        chk8("int_n_idle", {7'b0, int_n}, 8'h01);
`endif
    endtask

    task automatic io_write(logic [7:0] addr, logic [7:0] data, int waits);
        a      = addr;
        din    = data;
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        repeat (1 + waits) tick();
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        tick();
        tick();
    endtask

    task automatic io_read(string name, logic [7:0] addr, int waits,
                           logic [7:0] exp_dout, bit exp_oe);
        a      = addr;
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        #2;
        chk8({name, "_dout"}, dout, exp_dout);
        chk8({name, "_oe"}, {7'b0, dout_oe}, {7'b0, exp_oe});
        repeat (1 + waits) tick();
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        #2;
        chk8({name, "_oe_after"}, {7'b0, dout_oe}, 8'h00);
        tick();
        tick();
    endtask

    initial begin
        //           wr addr   data   w  cmd    dat    db cb dout   oe st sv zdo    mpage
        vt[0]  = '{1, 8'h03, 8'h5A, 2, 8'hC3, 8'h81, 0, 0, 8'h00, 0, 1, 1, 8'h5A, 8'h00};
        vt[1]  = '{0, 8'h01, 8'h00, 1, 8'hC3, 8'h81, 0, 0, 8'hC3, 1, 0, 0, 8'h5A, 8'h00};
        vt[2]  = '{0, 8'h02, 8'h00, 0, 8'hC3, 8'h81, 0, 0, 8'h81, 1, 1, 0, 8'h5A, 8'h00};
        vt[3]  = '{0, 8'h04, 8'h00, 0, 8'hC3, 8'h81, 1, 1, 8'h81, 1, 0, 0, 8'h5A, 8'h00};
        vt[4]  = '{0, 8'h14, 8'h00, 0, 8'hC3, 8'h81, 1, 1, 8'h81, 1, 0, 0, 8'h5A, 8'h00};
        vt[5]  = '{0, 8'h07, 8'h00, 0, 8'hC3, 8'h81, 1, 1, 8'h00, 0, 0, 0, 8'h5A, 8'h00};
        vt[6]  = '{1, 8'h05, 8'h5A, 0, 8'hC3, 8'h81, 1, 1, 8'h00, 0, 2, 0, 8'h5A, 8'h00};
        vt[7]  = '{1, 8'h0B, 8'h01, 0, 8'hC3, 8'h81, 1, 1, 8'h00, 0, 2, 1, 8'h5A, 8'h00};
        vt[8]  = '{1, 8'h0A, 8'h00, 0, 8'hC3, 8'h81, 1, 1, 8'h00, 0, 1, 0, 8'h5A, 8'h00};
        vt[9]  = '{1, 8'h00, 8'hFF, 0, 8'hC3, 8'h81, 1, 1, 8'h00, 0, 0, 0, 8'h5A, 8'h3F};
        vt[10] = '{0, 8'h00, 8'h00, 0, 8'hC3, 8'h81, 1, 1, 8'h3F, 1, 0, 0, 8'h5A, 8'h3F};
        vt[11] = '{0, 8'h0D, 8'h00, 0, 8'hC3, 8'h81, 1, 1, 8'h00, 0, 0, 0, 8'h5A, 8'h3F};
        vt[12] = '{1, 8'h0A, 8'hFF, 1, 8'hC3, 8'h81, 1, 1, 8'h00, 0, 1, 1, 8'h5A, 8'h3F};
        vt[13] = '{1, 8'h1B, 8'hFE, 0, 8'hC3, 8'h81, 1, 1, 8'h00, 0, 2, 0, 8'h5A, 8'h3F};
        vt[14] = '{0, 8'h12, 8'h00, 3, 8'h3C, 8'h96, 0, 0, 8'h96, 1, 1, 0, 8'h5A, 8'h3F};
        vt[15] = '{0, 8'h04, 8'h00, 0, 8'h3C, 8'h96, 0, 1, 8'h01, 1, 0, 0, 8'h5A, 8'h3F};
        vt[16] = '{1, 8'h0C, 8'h00, 0, 8'h3C, 8'h96, 0, 0, 8'h00, 0, 0, 0, 8'h5A, 8'h3F};
        vt[17] = '{1, 8'h03, 8'hA5, 0, 8'h3C, 8'h96, 0, 0, 8'h00, 0, 1, 1, 8'hA5, 8'h3F};

        repeat (2) @(negedge cpu_clock);
        chk8("rst_zdo", zx_data_out, 8'h00);
        chk8("rst_mpage", {2'b0, mpage}, 8'h00);
        chk8("rst_strobes", {6'b0, data_bit_wr, command_bit_wr}, 8'h00);
        chk8("rst_bits_in", {6'b0, data_bit_in, command_bit_in}, 8'h00);
        chk8("rst_int_n", {7'b0, int_n}, 8'h01);
        rst = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 18; i++) begin
            zx_command  = vt[i].cmd;
            zx_data_in  = vt[i].dat;
            data_bit    = vt[i].db;
            command_bit = vt[i].cb;
            if (vt[i].strobe != 0)
                expect_strobe(vt[i].strobe == 2, vt[i].sval);
            if (vt[i].wr)
                io_write(vt[i].addr, vt[i].data, vt[i].waits);
            else
                io_read($sformatf("v%0d", i), vt[i].addr, vt[i].waits,
                        vt[i].exp_dout, vt[i].exp_oe);
            chk8($sformatf("v%0d_zdo", i), zx_data_out, vt[i].exp_zdo);
            chk8($sformatf("v%0d_mpage", i), {2'b0, mpage}, vt[i].exp_mpage);
            chk8($sformatf("v%0d_dbi", i), {7'b0, data_bit_in}, {7'b0, exp_dbi});
            chk8($sformatf("v%0d_cbi", i), {7'b0, command_bit_in}, {7'b0, exp_cbi});
        end

        // Interrupt-acknowledge cycles must not be decoded
        a = 8'h03; din = 8'h11; m1_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (3) tick();
        iorq_n = 1'b1; wr_n = 1'b1;
        tick();
        a = 8'h02; iorq_n = 1'b0; rd_n = 1'b0;
        #2;
        chk8("m1_rd_oe", {7'b0, dout_oe}, 8'h00);
        repeat (3) tick();
        iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
        tick();
        tick();
        chk8("m1_zdo", zx_data_out, 8'hA5);

        // Read end and write start on the same edge: write wins
        a = 8'h02; iorq_n = 1'b0; rd_n = 1'b0;
        tick();
        tick();
        rd_n = 1'b1; wr_n = 1'b0; a = 8'h00; din = 8'h2A;
        tick();
        iorq_n = 1'b1; wr_n = 1'b1;
        tick();
        tick();
        chk8("simul_mpage", {2'b0, mpage}, 8'h2A);

        // Reset in the middle of an OUT ($00)
        a = 8'h00; din = 8'h15; iorq_n = 1'b0; wr_n = 1'b0;
        tick();
        tick();
        chk8("mid_pre_mpage", {2'b0, mpage}, 8'h15);
        rst = 1'b1;
        #1;
        chk8("mid_rst_mpage", {2'b0, mpage}, 8'h00);
        tick();
        rst = 1'b0;
        exp_dbi = 1'b0;
        exp_cbi = 1'b0;
        repeat (3) tick();
        iorq_n = 1'b1; wr_n = 1'b1;
        tick();
        tick();
        chk8("mid_post_mpage", {2'b0, mpage}, 8'h00);
        chk8("mid_post_dbi", {7'b0, data_bit_in}, 8'h00);

        // OUT ($03) and IN ($02) straddling reset release: no action
        a = 8'h03; din = 8'h77; iorq_n = 1'b0; wr_n = 1'b0; rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        iorq_n = 1'b1; wr_n = 1'b1;
        tick();
        tick();
        chk8("rst_out_zdo", zx_data_out, 8'h00);
        a = 8'h02; iorq_n = 1'b0; rd_n = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        iorq_n = 1'b1; rd_n = 1'b1;
        tick();
        tick();
        expect_strobe(0, 1);
        io_write(8'h03, 8'hC7, 1);
        chk8("rearm_zdo", zx_data_out, 8'hC7);

`ifdef GS_CMD_INT_EN
        command_bit = 1'b0;
        io_write(8'h0C, 8'h01, 0);
        int_low = 0;
        command_bit = 1'b1;
        repeat (50) tick();
        chk8("int_pulse_len", 8'(int_low), 8'd32);

        command_bit = 1'b0;
        tick();
        int_low = 0;
        command_bit = 1'b1;
        repeat (5) tick();
        io_write(8'h0C, 8'h00, 0);
        repeat (45) tick();
        chk8("int_clear_mid", 8'(int_low), 8'd32);

        command_bit = 1'b0;
        tick();
        int_low = 0;
        command_bit = 1'b1;
        repeat (40) tick();
        chk8("int_disabled", 8'(int_low), 8'd0);
`endif

        chk8("sb_empty", 8'(sbq.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
